// File: rtl/iir_block_seq.sv
// Block sequencer for the IIR datapath: clears the filter, streams len samples from
// dataX through it and writes the latency-aligned results into dataY.
module iir_block_seq #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int LAT = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  output logic          x_rd_en,
  output logic [AW-1:0] x_rd_addr,
  input  logic [DW-1:0] x_rd_data,
  output logic          filt_clr_n,
  output logic [DW-1:0] filt_in,
  input  logic [DW-1:0] filt_out,
  output logic          y_wr_en,
  output logic [AW-1:0] y_wr_addr,
  output logic [DW-1:0] y_wr_data,
  output logic          busy,
  output logic          done,
  output logic          data_valid,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic [AW:0] rd_cnt_q, rd_cnt_d;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic [AW:0] len_q, len_d;
  // [0] is the read-data-valid slot, [LAT] lines up with filt_out of that sample
  logic [LAT:0] vld_pipe_q, vld_pipe_d;
  logic        filt_clr_n_q, filt_clr_n_d;
  logic        data_valid_q, data_valid_d;
  logic        err_q, err_d;
  logic        len_ok;

  // the clear cycle right after accept holds off the first read
  assign x_rd_en    = (state_q == S_STREAM) && filt_clr_n_q;
  assign x_rd_addr  = x_rd_en ? rd_cnt_q[AW-1:0] : '0;
  assign filt_in    = vld_pipe_q[0] ? x_rd_data : '0;
  assign y_wr_en    = vld_pipe_q[LAT];
  assign y_wr_addr  = y_wr_en ? wr_cnt_q[AW-1:0] : '0;
  assign y_wr_data  = filt_out;
  assign filt_clr_n = filt_clr_n_q;
  assign busy       = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign data_valid = data_valid_q;
  assign err        = err_q;

  assign len_ok = (len != '0) && (len <= MAX_LEN);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_cnt_d     = x_rd_en ? rd_cnt_q + CNT_ONE : rd_cnt_q;
    wr_cnt_d     = y_wr_en ? wr_cnt_q + CNT_ONE : wr_cnt_q;
    vld_pipe_d   = {vld_pipe_q[LAT-1:0], x_rd_en};
    filt_clr_n_d = 1'b1;
    data_valid_d = data_valid_q;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_d      = S_STREAM;
            len_d        = len;
            rd_cnt_d     = '0;
            wr_cnt_d     = '0;
            filt_clr_n_d = 1'b0;
            data_valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d    = S_IDLE;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          vld_pipe_d = '0;
        end else if (x_rd_en && (rd_cnt_q == len_q - CNT_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d    = S_IDLE;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          vld_pipe_d = '0;
        end else if (wr_cnt_d == len_q) begin
          state_d      = S_DONE;
          data_valid_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      vld_pipe_q   <= '0;
      filt_clr_n_q <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      filt_clr_n_q <= filt_clr_n_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_iir_block_seq.sv
// Scoreboard bench for iir_block_seq: stimulus queues expected reads/writes/done/err
// by cycle; a negedge monitor pops and compares as the DUT presents them.
module tb_iir_block_seq;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LAT = 9;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW:0]   len;
  logic          x_rd_en;
  logic [AW-1:0] x_rd_addr;
  logic [DW-1:0] x_rd_data;
  logic          filt_clr_n;
  logic [DW-1:0] filt_in, filt_out;
  logic          y_wr_en;
  logic [AW-1:0] y_wr_addr;
  logic [DW-1:0] y_wr_data;
  logic          busy, done, data_valid, err;

  iir_block_seq #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .filt_clr_n(filt_clr_n), .filt_in(filt_in), .filt_out(filt_out),
    .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_wr_data(y_wr_data),
    .busy(busy), .done(done), .data_valid(data_valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // input buffer and a pure LAT-stage delay standing in for the filter
  logic [DW-1:0] x_mem [32];
  logic [DW-1:0] dly [LAT];
  always @(posedge clk) if (x_rd_en) x_rd_data <= x_mem[x_rd_addr];
  always @(posedge clk) begin
    if (!filt_clr_n) begin
      for (int i = 0; i < LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= filt_in;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end
  assign filt_out = dly[LAT-1];

  typedef struct { int cyc; int addr; logic [DW-1:0] data; } ev_t;
  ev_t rdq[$];
  ev_t wrq[$];
  int  dq[$];
  int  eq[$];

  int nvec = 0;
  int nfail = 0;
  int t0 = 0;
  int cur_n = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // monitor
  ev_t e;
  int  ec;
  always @(negedge clk) begin
    if (reset) begin
      while (rdq.size() > 0 && rdq[0].cyc < cyc) begin chk("rd_missing", cyc, rdq[0].cyc); e = rdq.pop_front(); end
      while (wrq.size() > 0 && wrq[0].cyc < cyc) begin chk("wr_missing", cyc, wrq[0].cyc); e = wrq.pop_front(); end
      while (dq.size() > 0 && dq[0] < cyc) begin chk("done_missing", cyc, dq[0]); ec = dq.pop_front(); end
      while (eq.size() > 0 && eq[0] < cyc) begin chk("err_missing", cyc, eq[0]); ec = eq.pop_front(); end
      if (x_rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", x_rd_en, 0);
        else begin
          e = rdq.pop_front();
          chk("rd_cyc", cyc, e.cyc);
          chk("rd_addr", x_rd_addr, e.addr);
        end
      end
      if (y_wr_en) begin
        if (wrq.size() == 0) chk("wr_unexpected", y_wr_en, 0);
        else begin
          e = wrq.pop_front();
          chk("wr_cyc", cyc, e.cyc);
          chk("wr_addr", y_wr_addr, e.addr);
          chk("wr_data", y_wr_data, e.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", done, 0);
        else begin ec = dq.pop_front(); chk("done_cyc", cyc, ec); end
      end
      if (err) begin
        if (eq.size() == 0) chk("err_unexpected", err, 0);
        else begin ec = eq.pop_front(); chk("err_cyc", cyc, ec); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // accept a run; expects reads for k<nrd, and writes/done only if full
  task automatic issue(input int n, input int nrd, input bit full);
    start = 1'b1;
    len   = (AW+1)'(n);
    t0    = cyc + 1;
    cur_n = n;
    for (int k = 0; k < nrd; k++) rdq.push_back('{t0 + 1 + k, k, '0});
    if (full) begin
      for (int k = 0; k < n; k++) wrq.push_back('{t0 + 2 + k + LAT, k, x_mem[k]});
      dq.push_back(t0 + 2 + n + LAT);
    end
    tick();
    start = 1'b0;
    chk("clr_T0", filt_clr_n, 0);
    chk("busy_T0", busy, 1);
    chk("dv_T0", data_valid, 0);
    chk("rd_en_T0", x_rd_en, 0);
    chk("filt_in_T0", filt_in, 0);
    tick();
    chk("clr_T1", filt_clr_n, 1);
    chk("rd_en_T1", x_rd_en, 1);
  endtask

  task automatic finish_run(input bit start_in_done);
    wait_until(t0 + cur_n + LAT + 1);
    chk("busy_last_wr", busy, 1);
    chk("done_early", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("dv_done", data_valid, 1);
    if (start_in_done) begin start = 1'b1; len = 4; end
    tick();
    start = 1'b0;
    chk("done_after", done, 0);
    chk("dv_sticky", data_valid, 1);
    chk("busy_after", busy, 0);
    if (start_in_done) begin tick(); chk("busy_ign_done", busy, 0); end
  endtask

  task automatic bad_start(input int n);
    start = 1'b1;
    len   = (AW+1)'(n);
    eq.push_back(cyc + 1);
    tick();
    start = 1'b0;
    chk("bad_busy", busy, 0);
    chk("bad_dv_kept", data_valid, 1);
    tick();
    chk("bad_busy2", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
    for (int k = 0; k < 32; k++) x_mem[k] = DW'(k + 1);
    repeat (3) tick();
    chk("rst_clr_n", filt_clr_n, 0);
    chk("rst_rd_en", x_rd_en, 0);
    chk("rst_wr_en", y_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_filt_in", filt_in, 0);
    reset = 1'b1;
    tick();
    chk("clr_n_release", filt_clr_n, 1);
    tick();

    // nominal full-depth run
    issue(32, 32, 1);
    finish_run(0);

    // single sample, filt_in zero outside its slot
    issue(1, 1, 1);
    for (int n = 1; n <= 10; n++) begin
      chk("short_filt_in", filt_in, (n == 2) ? x_mem[0] : 0);
      tick();
    end
    finish_run(0);

    // illegal lengths
    bad_start(0);
    bad_start(33);

    // abort sampled at T5, restart sampled at T8
    issue(32, 4, 0);
    wait_until(t0 + 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", x_rd_en, 0);
    chk("abort_wr_en", y_wr_en, 0);
    tick();
    chk("abort_dv", data_valid, 0);
    wait_until(t0 + 7);
    issue(32, 32, 1);
    finish_run(0);

    // start while busy and in DONE ignored
    issue(8, 8, 1);
    start = 1'b1; len = 5;
    tick(); tick();
    start = 1'b0;
    finish_run(1);

    // start+abort in IDLE ignored
    start = 1'b1; abort = 1'b1; len = 4;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    tick();
    chk("sa_busy2", busy, 0);
    chk("sa_dv", data_valid, 1);

    // back-to-back runs; data_valid clears at the second accept
    issue(3, 3, 1);
    finish_run(0);
    issue(2, 2, 1);
    finish_run(0);

    // reset during DRAIN
    for (int k = 0; k < 32; k++) x_mem[k] = 32'hA500_0000 + DW'(k * 7);
    issue(16, 16, 1);
    wait_until(t0 + 20);
    reset = 1'b0;
    rdq.delete(); wrq.delete(); dq.delete(); eq.delete();
    #1;
    chk("mid_rst_clr_n", filt_clr_n, 0);
    chk("mid_rst_rd_en", x_rd_en, 0);
    chk("mid_rst_wr_en", y_wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_filt_in", filt_in, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_release", filt_clr_n, 1);
    issue(5, 5, 1);
    finish_run(0);

    repeat (5) tick();
    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("eq_left", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
